fetch_prefetch_unit: RTL and testbench

- Instruction fetch stage that sits directly upstream of the issue register.
- Owns the fetch PC and issues word reads to main memory read port 0, which has 1-cycle read latency.
- Buffers returned instructions with their PCs in a small FIFO and presents them to issue through a valid/ready handshake.
- On a control-flow redirect (jump taken or squash), flushes all buffered and in-flight instructions.

---
 rtl/fetch_prefetch_unit.sv | 93 +++++++++
 tb/tb_fetch_prefetch_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch/prefetch stage: owns the fetch PC, keeps at most one memory
// read in flight and buffers returned words with their PCs for the issue handshake.
module fetch_prefetch_unit #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter logic [31:0] NOP_INSTR = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       mem_ren,
    output logic [31:0]                mem_raddr,
    input  logic [31:0]                mem_rdata,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    input  logic                       issue_ready,
    output logic                       issue_valid,
    output logic [31:0]                issue_instr,
    output logic [31:0]                issue_pc,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [31:0]      fetch_pc;
    logic             inflight_valid;
    logic [31:0]      inflight_pc;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      instr_buf [DEPTH];
    logic [31:0]      pc_buf    [DEPTH];
    logic             pop;
    logic             push;
    logic [CNT_W:0]   credit;

    assign issue_valid = (count != '0);
    assign issue_instr = issue_valid ? instr_buf[rd_ptr] : NOP_INSTR;
    assign issue_pc    = issue_valid ? pc_buf[rd_ptr] : 32'h0;
    assign occupancy   = count;

    assign pop  = issue_valid & issue_ready & ~redirect_valid;
    assign push = inflight_valid & ~redirect_valid;

    // Buffered entries plus the word still in flight, less the one leaving now.
    assign credit    = {1'b0, count} + {{CNT_W{1'b0}}, inflight_valid} - {{CNT_W{1'b0}}, pop};
    assign mem_ren   = ~rst & (redirect_valid | (credit < DEPTH_C));
    assign mem_raddr = redirect_valid ? redirect_pc : fetch_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc       <= RESET_PC;
            inflight_valid <= 1'b0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
        end else if (redirect_valid) begin
            fetch_pc       <= redirect_pc + 32'd1;
            inflight_valid <= 1'b1;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
        end else begin
            inflight_valid <= mem_ren;
            if (mem_ren) begin
                fetch_pc <= fetch_pc + 32'd1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push & ~pop) begin
                count <= count + CNT_W'(1);
            end else if (pop & ~push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Pure data: validity lives in inflight_valid and count, so no reset here.
    always_ff @(posedge clk) begin
        if (mem_ren) begin
            inflight_pc <= mem_raddr;
        end
        if (push) begin
            instr_buf[wr_ptr] <= mem_rdata;
            pc_buf[wr_ptr]    <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomized bench for fetch_prefetch_unit against a queue-based fetch/issue model.
module tb_fetch_prefetch_unit;
    localparam int          DEPTH   = 4;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] RPC1    = 32'h0;
    localparam logic [31:0] RPC2    = 32'hFFFF_FFFE;

    logic        clk;
    logic        rst;
    logic        mem_ren;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        issue_ready;
    logic        issue_valid;
    logic [31:0] issue_instr;
    logic [31:0] issue_pc;
    logic [$clog2(DEPTH+1)-1:0] occupancy;

    logic        rst2;
    logic        d2_ren;
    logic [31:0] d2_raddr;
    logic [31:0] d2_rdata;
    logic        d2_valid;
    logic [31:0] d2_instr;
    logic [31:0] d2_pc;
    logic [$clog2(DEPTH+1)-1:0] d2_occ;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [31:0] mq[$];
    logic        m_infl;
    logic [31:0] m_infl_pc;
    logic [31:0] m_next;
    logic [31:0] m_stream;

    fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC1), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .issue_ready(issue_ready),
        .issue_valid(issue_valid), .issue_instr(issue_instr), .issue_pc(issue_pc),
        .occupancy(occupancy)
    );

    fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC2), .NOP_INSTR(NOP)) dut_wrap (
        .clk(clk), .rst(rst2), .mem_ren(d2_ren), .mem_raddr(d2_raddr), .mem_rdata(d2_rdata),
        .redirect_valid(1'b0), .redirect_pc(32'h0), .issue_ready(1'b1),
        .issue_valid(d2_valid), .issue_instr(d2_instr), .issue_pc(d2_pc),
        .occupancy(d2_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000 + a;
    endfunction

    // Memory with 1-cycle read latency; garbage on cycles with no read.
    always @(posedge clk) begin
        mem_rdata <= mem_ren ? mem_word(mem_raddr) : $urandom;
        d2_rdata  <= d2_ren ? mem_word(d2_raddr) : $urandom;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        vec_cnt++;
        if (obs !== expd) begin
            err_cnt++;
            $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, expd, $time);
        end
    endtask

    // Called at a falling edge; asserts reset away from any rising edge.
    task automatic do_reset();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        issue_ready    = 1'($urandom_range(1));
        rst = 1'b1;
        #1;
        chk("rst_ren",   32'(mem_ren), 32'h0);
        chk("rst_valid", 32'(issue_valid), 32'h0);
        chk("rst_instr", issue_instr, NOP);
        chk("rst_pc",    issue_pc, 32'h0);
        chk("rst_occ",   32'(occupancy), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        m_infl   = 1'b0;
        m_next   = RPC1;
        m_stream = RPC1;
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
        logic        pop;
        logic        ren;
        logic [31:0] head;
        int          cnt;
        redirect_valid = rv;
        redirect_pc    = rpc;
        issue_ready    = rdy;
        #1;
        pop = (mq.size() != 0) && rdy && !rv;
        cnt = mq.size() + int'(m_infl) - int'(pop);
        ren = rv || (cnt < DEPTH);
        chk("valid", 32'(issue_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            head = mq[0];
            chk("instr", issue_instr, mem_word(head));
            chk("pc", issue_pc, head);
        end else begin
            chk("instr", issue_instr, NOP);
            chk("pc", issue_pc, 32'h0);
        end
        chk("occ", 32'(occupancy), 32'(mq.size()));
        chk("ren", 32'(mem_ren), 32'(ren));
        chk("raddr", mem_raddr, rv ? rpc : m_next);
        if (pop) begin
            chk("stream", issue_pc, m_stream);
            m_stream = m_stream + 32'd1;
            void'(mq.pop_front());
        end
        if (rv) begin
            mq.delete();
            m_infl    = 1'b1;
            m_infl_pc = rpc;
            m_next    = rpc + 32'd1;
            m_stream  = rpc;
        end else begin
            if (m_infl) mq.push_back(m_infl_pc);
            m_infl = ren;
            if (ren) begin
                m_infl_pc = m_next;
                m_next    = m_next + 32'd1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int          r;
        logic        rv;
        logic [31:0] rpc;
        rst = 1'b1;
        rst2 = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        issue_ready = 1'b0;
        mem_rdata = 32'h0;
        d2_rdata = 32'h0;
        @(negedge clk);

        // Wrapping fetch PC on the second instance.
        rst2 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (c == 0) begin
                chk("wrap_ren", 32'(d2_ren), 32'h1);
                chk("wrap_raddr", d2_raddr, RPC2);
            end
            if (c >= 2) begin
                chk("wrap_valid", 32'(d2_valid), 32'h1);
                chk("wrap_pc", d2_pc, RPC2 + 32'(c - 2));
                chk("wrap_instr", d2_instr, mem_word(RPC2 + 32'(c - 2)));
            end
            @(negedge clk);
        end

        // Straight-line fetch from reset.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);

        // Stall until the buffer fills, then drain.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1);

        // Redirect with three entries buffered and one in flight.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h40, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);

        // Back-to-back redirects.
        step(1'b1, 32'h10, 1'b1);
        step(1'b1, 32'h20, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);

        // Random traffic with occasional redirects and resets.
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(99));
            if (r < 1) begin
                do_reset();
            end else begin
                rv  = ($urandom_range(99) < 6);
                rpc = ($urandom_range(3) == 0) ? 32'hFFFF_FFFC + $urandom_range(3) : $urandom;
                step(rv, rpc, ($urandom_range(99) < 70));
            end
        end

        // Reset mid-stream with a full buffer, then restart.
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0);
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
